// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder with NUM_REGS software registers exposed on reg_out.
// The read and write channels run as independent two-state FSMs.
module axil_reg_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_REGS   = 4
) (
   input  logic                           ACLK,
   input  logic                           ARESET,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                     S_AXI_AWPROT,
   input  logic                           S_AXI_AWVALID,
   output logic                           S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                           S_AXI_WVALID,
   output logic                           S_AXI_WREADY,
   output logic [1:0]                     S_AXI_BRESP,
   output logic                           S_AXI_BVALID,
   input  logic                           S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                     S_AXI_ARPROT,
   input  logic                           S_AXI_ARVALID,
   output logic                           S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                     S_AXI_RRESP,
   output logic                           S_AXI_RVALID,
   input  logic                           S_AXI_RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int LSB   = 2;

   localparam logic [0:0] W_IDLE = 1'b0;
   localparam logic [0:0] W_RESP = 1'b1;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [0:0]              w_state_q, w_state_d;
   logic                    aw_held_q, aw_held_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic                    w_held_q, w_held_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic [1:0]              bresp_q, bresp_d;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

   logic [0:0]              r_state_q, r_state_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;

   logic                    aw_hs, w_hs, ar_hs;
   logic [IDX_W-1:0]        widx, ridx;
   logic                    unused_prot;

   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   // Address bits above the register index field must be zero.
   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
      return (addr >> (LSB + IDX_W)) == '0;
   endfunction

   assign S_AXI_AWREADY = !ARESET && (w_state_q == W_IDLE) && !aw_held_q;
   assign S_AXI_WREADY  = !ARESET && (w_state_q == W_IDLE) && !w_held_q;
   assign S_AXI_BVALID  = (w_state_q == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = !ARESET && (r_state_q == R_IDLE);
   assign S_AXI_RVALID  = (r_state_q == R_DATA);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_d = w_state_q;
      aw_held_d = aw_held_q;
      awaddr_d  = awaddr_q;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      regs_d    = regs_q;
      widx      = '0;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs) begin
               aw_held_d = 1'b1;
               awaddr_d  = S_AXI_AWADDR;
            end
            if (w_hs) begin
               w_held_d = 1'b1;
               wdata_d  = S_AXI_WDATA;
               wstrb_d  = S_AXI_WSTRB;
            end
            if (aw_held_d && w_held_d) begin
               widx = awaddr_d[LSB+IDX_W-1:LSB];
               if (in_range(awaddr_d)) begin
                  for (int b = 0; b < DATA_WIDTH/8; b++) begin
                     if (wstrb_d[b]) regs_d[widx][8*b +: 8] = wdata_d[8*b +: 8];
                  end
                  bresp_d = RESP_OKAY;
               end else begin
                  bresp_d = RESP_SLVERR;
               end
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
               w_state_d = W_RESP;
            end
         end
         W_RESP: if (S_AXI_BREADY) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   // Reads sample regs_q, so a same-cycle write is not yet visible.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      ridx      = S_AXI_ARADDR[LSB+IDX_W-1:LSB];
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               if (in_range(S_AXI_ARADDR)) begin
                  rdata_d = regs_q[ridx];
                  rresp_d = RESP_OKAY;
               end else begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end
               r_state_d = R_DATA;
            end
         end
         R_DATA: if (S_AXI_RREADY) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // NOTE: the register file is reset too, since software expects zeros after reset.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_q <= W_IDLE;
         aw_held_q <= 1'b0;
         awaddr_q  <= '0;
         w_held_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RESP_OKAY;
         for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
         r_state_q <= R_IDLE;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         // NOTE: non-blocking here so every flop samples pre-edge values.
         w_state_q <= w_state_d;
         aw_held_q <= aw_held_d;
         awaddr_q  <= awaddr_d;
         w_held_q  <= w_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         regs_q    <= regs_d;
         r_state_q <= r_state_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   always_comb begin
      reg_out = '0;
      for (int k = 0; k < NUM_REGS; k++) reg_out[DATA_WIDTH*k +: DATA_WIDTH] = regs_q[k];
   end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed bench for axil_reg_slave (ADDR_WIDTH=6 so out-of-range addresses exist).
module tb_axil_reg_slave;

   localparam int AW = 6;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic [AW-1:0] S_AXI_AWADDR;
   logic [2:0]    S_AXI_AWPROT;
   logic          S_AXI_AWVALID;
   logic          S_AXI_AWREADY;
   logic [31:0]   S_AXI_WDATA;
   logic [3:0]    S_AXI_WSTRB;
   logic          S_AXI_WVALID;
   logic          S_AXI_WREADY;
   logic [1:0]    S_AXI_BRESP;
   logic          S_AXI_BVALID;
   logic          S_AXI_BREADY;
   logic [AW-1:0] S_AXI_ARADDR;
   logic [2:0]    S_AXI_ARPROT;
   logic          S_AXI_ARVALID;
   logic          S_AXI_ARREADY;
   logic [31:0]   S_AXI_RDATA;
   logic [1:0]    S_AXI_RRESP;
   logic          S_AXI_RVALID;
   logic          S_AXI_RREADY;
   logic [127:0]  reg_out;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_regs [4];

   axil_reg_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_REGS(4)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .reg_out(reg_out)
   );

   always #5 ACLK = ~ACLK;

   function automatic logic [127:0] exp_flat();
      return {exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
   endfunction

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic aw_send(input logic [AW-1:0] a);
      S_AXI_AWADDR  = a;
      S_AXI_AWVALID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (S_AXI_AWREADY) begin
            tick();
            S_AXI_AWVALID = 1'b0;
            return;
         end
         tick();
      end
      S_AXI_AWVALID = 1'b0;
      checks++; errors++;
      $display("FAIL aw_timeout: AWREADY never seen, required 1");
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s);
      S_AXI_WDATA  = d;
      S_AXI_WSTRB  = s;
      S_AXI_WVALID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (S_AXI_WREADY) begin
            tick();
            S_AXI_WVALID = 1'b0;
            return;
         end
         tick();
      end
      S_AXI_WVALID = 1'b0;
      checks++; errors++;
      $display("FAIL w_timeout: WREADY never seen, required 1");
   endtask

   task automatic ar_send(input logic [AW-1:0] a);
      S_AXI_ARADDR  = a;
      S_AXI_ARVALID = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (S_AXI_ARREADY) begin
            tick();
            S_AXI_ARVALID = 1'b0;
            return;
         end
         tick();
      end
      S_AXI_ARVALID = 1'b0;
      checks++; errors++;
      $display("FAIL ar_timeout: ARREADY never seen, required 1");
   endtask

   task automatic b_recv(output logic [1:0] resp);
      resp = 2'bxx;
      S_AXI_BREADY = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (S_AXI_BVALID) begin
            resp = S_AXI_BRESP;
            tick();
            S_AXI_BREADY = 1'b0;
            return;
         end
         tick();
      end
      S_AXI_BREADY = 1'b0;
      checks++; errors++;
      $display("FAIL b_timeout: BVALID never seen, required 1");
   endtask

   task automatic r_recv(output logic [31:0] d, output logic [1:0] resp);
      d = 'x;
      resp = 2'bxx;
      S_AXI_RREADY = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (S_AXI_RVALID) begin
            d    = S_AXI_RDATA;
            resp = S_AXI_RRESP;
            tick();
            S_AXI_RREADY = 1'b0;
            return;
         end
         tick();
      end
      S_AXI_RREADY = 1'b0;
      checks++; errors++;
      $display("FAIL r_timeout: RVALID never seen, required 1");
   endtask

   task automatic write_txn(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      fork
         aw_send(a);
         w_send(d, s);
      join
      b_recv(resp);
   endtask

   task automatic read_txn(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
      ar_send(a);
      r_recv(d, resp);
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      tick();
      tick();
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ready_valid: got %b required 00000",
                  {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
      end
      checks++;
      if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA} !== 36'h0) begin
         errors++;
         $display("FAIL reset_resp_rdata: bresp=%b rresp=%b rdata=%h required 0",
                  S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA);
      end
      ARESET = 1'b0;
      tick();
      checks++;
      if (reg_out !== 128'h0) begin
         errors++;
         $display("FAIL reset_regs: got %h required 0", reg_out);
      end
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
         errors++;
         $display("FAIL idle_ready: got %b required 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
   endtask

   task automatic test_basic();
      logic [1:0]  resp;
      logic [31:0] d;
      for (int k = 0; k < 4; k++) begin
         write_txn(AW'(4 * k), 32'(k + 1), 4'hF, resp);
         exp_regs[k] = 32'(k + 1);
         checks++;
         if (resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_bresp[%0d]: got %b required 00", k, resp);
         end
      end
      checks++;
      if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
         errors++;
         $display("FAIL basic_reg_out: got %h required 00000004000000030000000200000001", reg_out);
      end
      for (int k = 0; k < 4; k++) begin
         read_txn(AW'(4 * k), d, resp);
         checks++;
         if (d !== 32'(k + 1) || resp !== 2'b00) begin
            errors++;
            $display("FAIL basic_read[%0d]: got %h/%b required %h/00", k, d, resp, k + 1);
         end
      end
   endtask

   task automatic test_order();
      logic [1:0] resp;
      aw_send(6'h04);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b001 || reg_out !== exp_flat()) begin
            errors++;
            $display("FAIL aw_first_wait[%0d]: bvalid/awready/wready=%b required 001, reg_out=%h",
                     i, {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, reg_out);
         end
         tick();
      end
      S_AXI_WDATA = 32'hA5A5_0001; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      exp_regs[1] = 32'hA5A5_0001;
      checks++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00 || reg_out !== exp_flat()) begin
         errors++;
         $display("FAIL aw_first_done: bvalid=%b bresp=%b reg_out=%h required 1/00/%h",
                  S_AXI_BVALID, S_AXI_BRESP, reg_out, exp_flat());
      end
      b_recv(resp);

      w_send(32'h5A5A_0002, 4'hF);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b010 || reg_out !== exp_flat()) begin
            errors++;
            $display("FAIL w_first_wait[%0d]: bvalid/awready/wready=%b required 010, reg_out=%h",
                     i, {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, reg_out);
         end
         tick();
      end
      S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      exp_regs[1] = 32'h5A5A_0002;
      checks++;
      if (S_AXI_BVALID !== 1'b1 || reg_out !== exp_flat()) begin
         errors++;
         $display("FAIL w_first_done: bvalid=%b reg_out=%h required 1/%h", S_AXI_BVALID, reg_out, exp_flat());
      end
      b_recv(resp);
      tick();
      checks++;
      if (S_AXI_BVALID !== 1'b0 || reg_out !== exp_flat()) begin
         errors++;
         $display("FAIL single_write: bvalid=%b reg_out=%h required 0/%h", S_AXI_BVALID, reg_out, exp_flat());
      end
   endtask

   task automatic test_strobe();
      logic [1:0] resp;
      write_txn(6'h08, 32'hAABB_CCDD, 4'hF, resp);
      write_txn(6'h08, 32'h1122_3344, 4'b0101, resp);
      exp_regs[2] = 32'hAA22_CC44;
      checks++;
      if (reg_out[95:64] !== 32'hAA22_CC44 || resp !== 2'b00) begin
         errors++;
         $display("FAIL strobe: reg2=%h bresp=%b required aa22cc44/00", reg_out[95:64], resp);
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] resp;
      fork
         aw_send(6'h0C);
         w_send(32'hDEAD_BEEF, 4'hF);
      join
      exp_regs[3] = 32'hDEAD_BEEF;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY} !== 5'b10000) begin
            errors++;
            $display("FAIL b_stall[%0d]: bvalid/bresp/awready/wready=%b required 10000",
                     i, {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY});
         end
         tick();
      end
      b_recv(resp);
      ar_send(6'h0C);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'hDEAD_BEEF || S_AXI_RRESP !== 2'b00 ||
             S_AXI_ARREADY !== 1'b0) begin
            errors++;
            $display("FAIL r_stall[%0d]: rvalid=%b rdata=%h rresp=%b arready=%b required 1/deadbeef/00/0",
                     i, S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_ARREADY);
         end
         tick();
      end
      S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_out_of_range();
      logic [1:0]  resp;
      logic [31:0] d;
      write_txn(6'h20, 32'hFFFF_FFFF, 4'hF, resp);
      checks++;
      if (resp !== 2'b10 || reg_out !== exp_flat()) begin
         errors++;
         $display("FAIL oor_write: bresp=%b reg_out=%h required 10/%h", resp, reg_out, exp_flat());
      end
      read_txn(6'h20, d, resp);
      checks++;
      if (resp !== 2'b10 || d !== 32'h0) begin
         errors++;
         $display("FAIL oor_read: rresp=%b rdata=%h required 10/00000000", resp, d);
      end
   endtask

   task automatic test_simul_rw();
      S_AXI_AWADDR = 6'h00; S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA = 32'h0000_0077; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      S_AXI_ARADDR = 6'h00; S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_regs[0]) begin
         errors++;
         $display("FAIL simul_read_old: rvalid=%b rdata=%h required 1/%h", S_AXI_RVALID, S_AXI_RDATA, exp_regs[0]);
      end
      exp_regs[0] = 32'h0000_0077;
      checks++;
      if (S_AXI_BVALID !== 1'b1 || reg_out !== exp_flat()) begin
         errors++;
         $display("FAIL simul_write: bvalid=%b reg_out=%h required 1/%h", S_AXI_BVALID, reg_out, exp_flat());
      end
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_back_to_back();
      S_AXI_ARADDR = 6'h04; S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_ARADDR = 6'h08; S_AXI_RREADY = 1'b1;
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_regs[1] || S_AXI_ARREADY !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first: rvalid=%b rdata=%h arready=%b required 1/%h/0",
                  S_AXI_RVALID, S_AXI_RDATA, S_AXI_ARREADY, exp_regs[1]);
      end
      tick();
      checks++;
      if (S_AXI_RVALID !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
         errors++;
         $display("FAIL b2b_gap: rvalid=%b arready=%b required 0/1", S_AXI_RVALID, S_AXI_ARREADY);
      end
      tick();
      S_AXI_ARVALID = 1'b0;
      checks++;
      if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== exp_regs[2]) begin
         errors++;
         $display("FAIL b2b_second: rvalid=%b rdata=%h required 1/%h", S_AXI_RVALID, S_AXI_RDATA, exp_regs[2]);
      end
      tick();
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [1:0]  resp;
      logic [31:0] d;
      fork
         aw_send(6'h00);
         w_send(32'h0000_0099, 4'hF);
      join
      ar_send(6'h04);
      checks++;
      if (S_AXI_BVALID !== 1'b1 || S_AXI_RVALID !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_valids: bvalid=%b rvalid=%b required 1/1", S_AXI_BVALID, S_AXI_RVALID);
      end
      #2 ARESET = 1'b1;
      #1;
      checks++;
      if (S_AXI_BVALID !== 1'b0 || S_AXI_RVALID !== 1'b0 || reg_out !== 128'h0) begin
         errors++;
         $display("FAIL async_reset: bvalid=%b rvalid=%b reg_out=%h required 0/0/0",
                  S_AXI_BVALID, S_AXI_RVALID, reg_out);
      end
      tick();
      ARESET = 1'b0;
      for (int k = 0; k < 4; k++) exp_regs[k] = '0;
      tick();
      for (int k = 0; k < 4; k++) begin
         read_txn(AW'(4 * k), d, resp);
         checks++;
         if (d !== 32'h0 || resp !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_read[%0d]: got %h/%b required 00000000/00", k, d, resp);
         end
      end
   endtask

   initial begin
      ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b0;
      for (int k = 0; k < 4; k++) exp_regs[k] = '0;

      test_reset();
      test_basic();
      test_order();
      test_strobe();
      test_backpressure();
      test_out_of_range();
      test_simul_rw();
      test_back_to_back();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder (slave) holding NUM_REGS 32-bit software registers.
- Answers the master sequence used on S00_AXI: single-beat writes to word addresses 0x0, 0x4, 0x8 and 0xC, then single-beat reads that must return the written data.
- Sits behind the bus interconnect. Register contents go to detector control logic through reg_out.

Parameters:
- DATA_WIDTH, 32, AXI data width. Only 32 is supported.
- ADDR_WIDTH, 4, AXI address width. Must be at least 2 + log2(NUM_REGS).
- NUM_REGS, 4, number of registers. Power of two, 2..16.

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- ARESET  in  1  asynchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  DATA_WIDTH  write data
- S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  DATA_WIDTH  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- reg_out  out  NUM_REGS*DATA_WIDTH  register contents; reg k occupies bits [32k+31:32k]

Behaviour:
- Reset (async assert, sync release):
  - All ready, valid and resp outputs 0; RDATA 0.
  - All registers 0.
  - FSMs go to idle.
  - Assertion mid-transaction abandons it; no partial write survives.
- Decode:
  - Index = addr[2+log2(NUM_REGS)-1:2]. addr[1:0] ignored.
  - Address bits above the index field nonzero -> out of range.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: AWREADY = 1 until AW is captured; WREADY = 1 until W is captured.
  - AW and W may arrive in either order or in the same cycle; each is latched independently.
  - When both are held, the write is performed on the next edge and the FSM moves to W_RESP with BVALID = 1.
  - Write applies byte lanes where WSTRB = 1; other bytes keep their old value.
  - In range -> BRESP = OKAY (00). Out of range -> no register change, BRESP = SLVERR (10).
  - W_RESP: AWREADY = WREADY = 0. BVALID holds, and BRESP stays stable, until BREADY is sampled high. Then return to W_IDLE.
  - Minimum latency: AW/W handshake at cycle 0 -> BVALID at cycle 1. reg_out reflects the new value in cycle 1.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ARREADY = 1. On handshake, register data is captured into RDATA/RRESP on the same edge, then the FSM moves to R_DATA with RVALID = 1 in the next cycle.
  - Out of range -> RDATA = 0, RRESP = SLVERR.
  - R_DATA: ARREADY = 0. RVALID, RDATA and RRESP hold until RREADY. Then return to R_IDLE.
  - RVALID and RREADY both high in the same cycle as a new ARVALID: the new AR is not accepted until the following cycle. Maximum one outstanding read.
- Simultaneous read and write to the same register in one cycle: the read returns the pre-write value.
- Read and write channels are fully independent; neither stalls the other.
- One outstanding write and one outstanding read at most.

Test Plan:
- Reset, then write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC and read back each in order -> BRESP = 00, RDATA = 0x1..0x4, RRESP = 00. reg_out = 0x00000004_00000003_00000002_00000001.
- AW 3 cycles before W, then W 3 cycles before AW, both to 0x4 -> single write per transaction. BVALID exactly 1 cycle after the later handshake; reg1 updated once.
- reg2 = 0xAABBCCDD; write 0x11223344 with WSTRB = 0101 -> reg2 = 0xAA22CC44.
- BREADY held low 5 cycles -> BVALID and BRESP stable; AWREADY = WREADY = 0 throughout. RREADY held low likewise -> RDATA stable.
- ADDR_WIDTH = 6, write and read 0x20 -> BRESP = 10, RRESP = 10, RDATA = 0. reg0..3 unchanged.
- ARESET pulsed while BVALID = 1 and RVALID = 1 -> all valids drop immediately (async), registers read 0 afterwards.
